router_fifo_reader: RTL and testbench
=====================================

Name: router_fifo_reader

Overview:
- Drains one router output FIFO and delivers bytes to the destination client over a valid/ready interface.
- Parses the packet format {header = payload_len[7:2], addr[1:0]; payload bytes; parity byte} and marks packet boundaries.
- Checks parity and reports errors.
- Watchdog: if the client stalls, the reader issues soft_reset to the FIFO and aborts the packet.
- Instantiated once per router output port, between router_fifo and the client.

Parameters:
- DATA_WIDTH, 8, FIFO/client byte width.
- TIMEOUT, 30, consecutive stalled cycles before soft reset.
- CNT_WIDTH, 5, watchdog counter width; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clock  in  1  single clock; all logic on posedge
- resetn  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_data_out  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_read_enb is sampled high
- fifo_read_enb  out  1  FIFO read strobe
- fifo_soft_reset  out  1  one-cycle pulse that flushes the FIFO
- dout  out  DATA_WIDTH  byte to client
- dout_valid  out  1  dout holds a valid byte
- dout_ready  in  1  client accepts the byte when valid&&ready at posedge
- dout_first  out  1  dout is a header byte
- dout_last  out  1  dout is a parity byte
- dest_addr  out  2  addr field of the current packet header
- parity_err  out  1  qualified by dout_valid&&dout_last; 1 = computed XOR != parity byte
- timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset (resetn low, asynchronous): all outputs 0; state IDLE; buffer empty; nothing in flight; counters 0.
- Output buffer: 2-entry skid queue; head drives dout/dout_first/dout_last/parity_err.
- Read issue: fifo_read_enb = !fifo_empty && state != FLUSH && (occupancy + inflight) < 2, with occupancy counted after this cycle's pop.
  - Returned byte is enqueued one cycle later.
  - Sustained throughput is 1 byte/cycle when dout_ready is held high.
- Latency: first byte of a packet appears on dout 2 cycles after fifo_read_enb is first asserted.
- Parser state machine, advanced on each returned byte:
  - HDR: byte tagged first; latch dest_addr = byte[1:0], remaining = byte[7:2], xor = byte. If remaining == 0 go to PAR, else go to PAY.
  - PAY: xor ^= byte; remaining--; go to PAR when remaining reaches 0.
  - PAR: byte tagged last; parity_err tag = (xor != byte); go to HDR.
  - FLUSH: entered on watchdog expiry; lasts 1 cycle; returns to HDR.
  - IDLE equals HDR with an empty buffer; the state is explicit only for reset.
- Lengths: payload_len 0 is legal, giving a 2-byte packet (header, parity). Maximum is 63 payload bytes.
- dest_addr updates when the header byte is enqueued and holds until the next header. addr = 3 is passed through, not flagged.
- Watchdog:
  - Counts cycles with dout_valid && !dout_ready.
  - Clears on any accept or when dout_valid is low.
  - When the count reaches TIMEOUT-1 while still stalled, the next cycle:
    - pulses fifo_soft_reset and timeout_err for one cycle;
    - empties the buffer and drops dout_valid;
    - discards any in-flight return byte;
    - enters FLUSH, then HDR. The next byte read is treated as a header.
- Simultaneous events:
  - Pop and push in the same cycle: occupancy is unchanged and order is preserved.
  - Watchdog expiry and a byte return in the same cycle: the byte is discarded.
  - fifo_empty rising while a read is in flight: the in-flight byte is still accepted.
- Mid-packet async reset: immediate clear; the packet is not resumed.

Decomposition:
- Shared package router_pkg holds:
  - constants HDR_LEN_MSB = 7, HDR_LEN_LSB = 2, ADDR_MSB = 1, ADDR_LSB = 0;
  - the parser state encoding (IDLE, HDR, PAY, PAR, FLUSH);
  - the default TIMEOUT.
- One sub-module: router_skid_buf, the 2-entry queue carrying {data, first, last, perr} with push/pop/flush.

Test Plan:
- Reset mid-packet (resetn low during PAY): all outputs 0 asynchronously; after release, a fresh packet 0x08, A1, A2, 0x0B is delivered with dout_first on 0x08.
- Header 0x3D (len 15, addr 1), 15 payload bytes, correct parity, dout_ready = 1: 17 bytes on consecutive cycles; dout_first only on byte 0; dout_last on byte 16; dest_addr = 1; parity_err = 0.
- Header 0x02 (len 0, addr 2), parity byte 0x02: 2-byte packet; dout_last on the second byte; parity_err = 0. Repeat with parity byte 0xFF: parity_err = 1.
- Back-to-back packets with dout_ready toggling 1/0 each cycle: no byte lost or duplicated; boundaries correct; fifo_read_enb never asserted while fifo_empty = 1.
- dout_ready held 0 with dout_valid = 1 for 30 cycles: fifo_soft_reset and timeout_err pulse exactly once, on the cycle after the 30th stalled cycle; dout_valid then 0. After refill, the next byte is reported with dout_first.
- dout_ready held 0 for 29 cycles then 1: no soft reset; the watchdog restarts from 0 on the next stall.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port reader: header field positions,
// parser state encoding and the per-byte tag carried alongside each data byte.
package router_pkg;

    localparam int unsigned HDR_LEN_MSB     = 7;
    localparam int unsigned HDR_LEN_LSB     = 2;
    localparam int unsigned ADDR_MSB        = 1;
    localparam int unsigned ADDR_LSB        = 0;
    localparam int unsigned LEN_WIDTH       = HDR_LEN_MSB - HDR_LEN_LSB + 1;
    localparam int unsigned DEFAULT_TIMEOUT = 30;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPay,
        StPar,
        StFlush
    } parser_state_e;

    typedef struct packed {
        logic first;
        logic last;
        logic perr;
    } byte_tag_t;

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry in-order queue between the FIFO return path and the client.
// Simultaneous push and pop keep occupancy and order; flush empties it at once.
module router_skid_buf #(
    parameter int unsigned Width = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [1:0]       count_o,
    output logic [Width-1:0] data_o
);

    logic [Width-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop_eff;

    assign pop_eff = pop_i && (cnt_q != 2'd0);
    // Tail slot is head + occupancy (mod 2); with two entries it aliases the head being popped.
    assign wr_ptr  = rd_ptr_q ^ cnt_q[0];

    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            cnt_d = cnt_q + 2'(push_i) - 2'(pop_eff);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (flush_i) begin
                rd_ptr_q <= 1'b0;
            end else if (pop_eff) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push_i && !flush_i) begin
                mem_q[wr_ptr] <= data_i;
            end
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/router_fifo_reader.sv
// Router output-port reader: drains router_fifo, frames header/payload/parity,
// checks parity and flushes the FIFO when the client stalls for too long.
module router_fifo_reader
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_read_enb,
    output logic                  fifo_soft_reset,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_first,
    output logic                  dout_last,
    output logic [1:0]            dest_addr,
    output logic                  parity_err,
    output logic                  timeout_err
);

    localparam int unsigned WORD_WIDTH = DATA_WIDTH + 3;

    parser_state_e         state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] xor_q, xor_d;
    logic [1:0]            dest_q, dest_d;
    logic [CNT_WIDTH-1:0]  wd_q, wd_d;
    logic                  inflight_q, expire_q, run_q;

    logic                  buf_valid, pop, push, stalled, expire, rd_en;
    logic [1:0]            buf_count;
    logic [WORD_WIDTH-1:0] push_word, head_word;
    byte_tag_t             push_tag, head_tag;

    assign pop     = buf_valid && dout_ready;
    assign stalled = buf_valid && !dout_ready;
    assign expire  = stalled && (wd_q == CNT_WIDTH'(TIMEOUT - 1));
    // A byte returning on the expiry edge is dropped together with the buffer contents.
    assign push    = inflight_q && !expire;
    assign rd_en   = run_q && !fifo_empty && (state_q != StFlush) &&
                     ((3'(buf_count) - 3'(pop) + 3'(inflight_q)) < 3'd2);
    assign wd_d    = (stalled && !expire) ? wd_q + CNT_WIDTH'(1) : '0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rem_q      <= '0;
            xor_q      <= '0;
            dest_q     <= '0;
            wd_q       <= '0;
            inflight_q <= 1'b0;
            expire_q   <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            rem_q      <= rem_d;
            xor_q      <= xor_d;
            dest_q     <= dest_d;
            wd_q       <= wd_d;
            inflight_q <= rd_en && !expire;
            expire_q   <= expire;
            run_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        xor_d   = xor_q;
        dest_d  = dest_q;
        if (expire) begin
            state_d = StFlush;
        end else if (state_q == StFlush) begin
            state_d = StHdr;
        end else if (push) begin
            unique case (state_q)
                StIdle, StHdr: begin
                    dest_d  = fifo_data_out[ADDR_MSB:ADDR_LSB];
                    rem_d   = fifo_data_out[HDR_LEN_MSB:HDR_LEN_LSB];
                    xor_d   = fifo_data_out;
                    state_d = (fifo_data_out[HDR_LEN_MSB:HDR_LEN_LSB] == '0) ? StPar : StPay;
                end
                StPay: begin
                    xor_d = xor_q ^ fifo_data_out;
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = StPar;
                    end
                end
                StPar:   state_d = StHdr;
                default: state_d = StHdr;
            endcase
        end
    end

    always_comb begin
        push_tag.first  = (state_q == StIdle) || (state_q == StHdr);
        push_tag.last   = (state_q == StPar);
        push_tag.perr   = (state_q == StPar) && (xor_q != fifo_data_out);
        push_word       = {fifo_data_out, push_tag};
        head_tag        = head_word[2:0];
        fifo_read_enb   = rd_en;
        fifo_soft_reset = expire_q;
        timeout_err     = expire_q;
        dest_addr       = dest_q;
        dout            = head_word[WORD_WIDTH-1:3];
        dout_valid      = buf_valid;
        dout_first      = buf_valid && head_tag.first;
        dout_last       = buf_valid && head_tag.last;
        parity_err      = buf_valid && head_tag.perr;
    end

    router_skid_buf #(
        .Width (WORD_WIDTH)
    ) u_skid_buf (
        .clk_i   (clock),
        .rst_ni  (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (expire),
        .data_i  (push_word),
        .valid_o (buf_valid),
        .count_o (buf_count),
        .data_o  (head_word)
    );

endmodule

// File: tb/tb_router_fifo_reader.sv
// Bench for router_fifo_reader: models the FIFO, predicts the delivered byte stream
// with packet tags, and predicts watchdog pulses from the client stall history.
module tb_router_fifo_reader;

    localparam int TIMEOUT = 30;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] data;
        logic       first;
        logic       last;
        logic       perr;
        logic [1:0] addr;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       fifo_empty;
    logic [7:0] fifo_data_out;
    logic       fifo_read_enb;
    logic       fifo_soft_reset;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       dout_first;
    logic       dout_last;
    logic [1:0] dest_addr;
    logic       parity_err;
    logic       timeout_err;

    always #5 clock = ~clock;

    router_fifo_reader dut (
        .clock           (clock),
        .resetn          (resetn),
        .fifo_empty      (fifo_empty),
        .fifo_data_out   (fifo_data_out),
        .fifo_read_enb   (fifo_read_enb),
        .fifo_soft_reset (fifo_soft_reset),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .dout_first      (dout_first),
        .dout_last       (dout_last),
        .dest_addr       (dest_addr),
        .parity_err      (parity_err),
        .timeout_err     (timeout_err)
    );

    int         ncomp = 0;
    int         nfail = 0;
    int         cycle = 0;
    int         stall_run = 0;
    int         npulse = 0;
    int         first_rd = -1;
    int         first_valid = -1;
    int         ready_mode = 0;
    logic       pulse_exp = 1'b0;
    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    int         acc_cycles[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncomp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cycle);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, 32'(dout), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_first"}, 32'(dout_first), 0);
        chk({tag, "_last"}, 32'(dout_last), 0);
        chk({tag, "_addr"}, 32'(dest_addr), 0);
        chk({tag, "_perr"}, 32'(parity_err), 0);
        chk({tag, "_rd"}, 32'(fifo_read_enb), 0);
        chk({tag, "_srst"}, 32'(fifo_soft_reset), 0);
        chk({tag, "_terr"}, 32'(timeout_err), 0);
    endtask

    // Packet rules: first byte is the header, last is parity over all earlier bytes.
    task automatic push_raw(input bq_t b);
        int         n;
        logic [7:0] x;
        logic [7:0] hdr;
        exp_t       e;
        n   = b.size();
        x   = 8'h00;
        hdr = b[0];
        for (int i = 0; i < n - 1; i++) x ^= b[i];
        for (int i = 0; i < n; i++) begin
            e.data  = b[i];
            e.first = (i == 0);
            e.last  = (i == n - 1);
            e.perr  = (i == n - 1) && (x != b[n-1]);
            e.addr  = hdr[1:0];
            exp_q.push_back(e);
            fifo_q.push_back(b[i]);
        end
        fifo_empty = 1'b0;
    endtask

    task automatic push_pkt(input int len, input logic [1:0] addr, input bit corrupt);
        bq_t        b;
        logic [7:0] x;
        logic [7:0] p;
        logic [5:0] l;
        l = 6'(len);
        x = {l, addr};
        b.push_back(x);
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom_range(0, 255));
            b.push_back(p);
            x ^= p;
        end
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        b.push_back(x);
        push_raw(b);
    endtask

    task automatic step();
        logic rd;
        logic sr;
        logic stalled;
        exp_t e;
        @(negedge clock);
        cycle++;
        if (first_rd < 0 && fifo_read_enb) first_rd = cycle;
        if (first_valid < 0 && dout_valid) first_valid = cycle;
        chk("rd_while_empty", 32'(fifo_read_enb && fifo_empty), 0);
        chk("soft_reset", 32'(fifo_soft_reset), 32'(pulse_exp));
        chk("timeout_err", 32'(timeout_err), 32'(pulse_exp));
        if (pulse_exp) chk("valid_in_flush", 32'(dout_valid), 0);
        if (fifo_soft_reset) npulse++;
        if (dout_valid && dout_ready) begin
            acc_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                ncomp++;
                nfail++;
                $error("FAIL extra_byte: observed %0h expected no byte (cycle %0d)", dout, cycle);
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(dout), 32'(e.data));
                chk("first", 32'(dout_first), 32'(e.first));
                chk("last", 32'(dout_last), 32'(e.last));
                if (e.last) chk("parity_err", 32'(parity_err), 32'(e.perr));
                if (e.first) chk("dest_addr", 32'(dest_addr), 32'(e.addr));
            end
        end
        stalled   = dout_valid && !dout_ready;
        stall_run = stalled ? stall_run + 1 : 0;
        pulse_exp = (stall_run == TIMEOUT);
        if (pulse_exp) stall_run = 0;
        rd = fifo_read_enb;
        sr = fifo_soft_reset;
        @(posedge clock);
        #1;
        if (rd && fifo_q.size() != 0) fifo_data_out = fifo_q.pop_front();
        if (sr) begin
            fifo_q.delete();
            exp_q.delete();
        end
        fifo_empty = (fifo_q.size() == 0);
        if (ready_mode == 1) dout_ready = !dout_ready;
        else if (ready_mode == 2) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string tag, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 0);
        repeat (3) step();
    endtask

    initial begin
        bq_t b;
        resetn        = 1'b1;
        fifo_empty    = 1'b1;
        fifo_data_out = 8'h00;
        dout_ready    = 1'b0;
        #1 resetn = 1'b0;
        #1 chk_all_zero("por");
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // Reset in the middle of a payload, then a fresh packet.
        dout_ready = 1'b1;
        push_pkt(10, 2'd3, 1'b0);
        repeat (6) step();
        resetn = 1'b0;
        #1 chk_all_zero("mid_reset");
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        pulse_exp  = 1'b0;
        stall_run  = 0;
        @(posedge clock);
        @(posedge clock);
        #1 resetn = 1'b1;
        first_rd    = -1;
        first_valid = -1;
        b.delete();
        b.push_back(8'h08); b.push_back(8'hA1); b.push_back(8'hA2); b.push_back(8'h0B);
        push_raw(b);
        drain("drain_after_reset", 50);
        chk("latency", 32'(first_valid - first_rd), 2);

        // Full-rate 17-byte packet.
        acc_cycles.delete();
        push_pkt(15, 2'd1, 1'b0);
        drain("drain_burst", 100);
        chk("burst_count", 32'(acc_cycles.size()), 17);
        if (acc_cycles.size() == 17) chk("burst_span", 32'(acc_cycles[16] - acc_cycles[0]), 16);

        // Zero-length packets, good and bad parity.
        b.delete();
        b.push_back(8'h02); b.push_back(8'h02);
        push_raw(b);
        b.delete();
        b.push_back(8'h02); b.push_back(8'hFF);
        push_raw(b);
        drain("drain_len0", 50);

        // Back-to-back random packets with a toggling client, then a random client.
        ready_mode = 1;
        for (int i = 0; i < 6; i++) begin
            push_pkt($urandom_range(0, 12), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        drain("drain_toggle", 2000);
        ready_mode = 2;
        for (int i = 0; i < 6; i++) begin
            push_pkt($urandom_range(0, 20), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        drain("drain_random", 4000);

        // Stalled client long enough to trip the watchdog, then refill.
        ready_mode = 0;
        dout_ready = 1'b0;
        npulse     = 0;
        push_pkt(10, 2'd2, 1'b0);
        repeat (45) step();
        chk("timeout_pulses", 32'(npulse), 1);
        chk("timeout_valid_low", 32'(dout_valid), 0);
        dout_ready = 1'b1;
        push_pkt(5, 2'd1, 1'b0);
        drain("drain_after_timeout", 100);

        // Stalls one cycle short of the limit, separated by an accept.
        npulse     = 0;
        dout_ready = 1'b1;
        push_pkt(40, 2'd0, 1'b0);
        repeat (4) step();
        dout_ready = 1'b0;
        repeat (TIMEOUT - 1) step();
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        repeat (TIMEOUT - 1) step();
        dout_ready = 1'b1;
        drain("drain_near_timeout", 200);
        chk("near_timeout_pulses", 32'(npulse), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed no finish expected finish by 400000");
        $fatal(1, "bench time limit reached");
    end

endmodule
